// File: rtl/vita49_pack_if.sv
// 32-bit AXI-Stream bundle used on both sides of the VITA-49 packetizer.
interface vita49_pack_if;
  logic        TVALID;
  logic        TREADY;
  logic [31:0] TDATA;
  logic [3:0]  TSTRB;
  logic        TLAST;

  modport master (output TVALID, TDATA, TSTRB, TLAST, input TREADY);
  modport slave  (input TVALID, TDATA, TSTRB, TLAST, output TREADY);
endinterface

// File: rtl/vita49_pack.sv
// VITA-49 IF-data packetizer: five-word prologue (header, stream ID, TSI, TSF)
// followed by a fixed-length payload passed straight through from the sample stream.
module vita49_pack #(
  parameter int unsigned C_AXIS_TDATA_NUM_BYTES = 4
) (
  input  logic          AXIS_ACLK,
  input  logic          AXIS_ARESETN,
  vita49_pack_if.slave  S_AXIS,
  vita49_pack_if.master M_AXIS,
  input  logic          enable,
  input  logic [31:0]   stream_id,
  input  logic [15:0]   payload_words,
  input  logic [31:0]   tsi,
  input  logic [63:0]   tsf,
  output logic          busy,
  output logic [31:0]   pkt_sent
);

  if (C_AXIS_TDATA_NUM_BYTES != 4) begin : g_width_check
    $error("vita49_pack supports only C_AXIS_TDATA_NUM_BYTES = 4");
  end

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    SID,
    TSI,
    TSF_HI,
    TSF_LO,
    PAYLOAD
  } state_t;

  state_t      state;
  logic [3:0]  pkt_cnt;
  logic [15:0] beat;
  logic [15:0] lat_len;
  logic [31:0] lat_sid;
  logic [31:0] lat_tsi;
  logic [63:0] lat_tsf;
  logic [31:0] pro_data;
  logic        pro_valid;
  logic [15:0] len_clamped;
  logic [15:0] last_beat;
  logic        unused_tlast;

  // Framing is driven purely by the latched length; the input TLAST is not used.
  assign unused_tlast = S_AXIS.TLAST;
  assign last_beat    = lat_len - 16'd1;

  always_comb begin
    len_clamped = payload_words;
    if (payload_words == '0) begin
      len_clamped = 16'd1;
    end else if (payload_words > 16'd65530) begin
      len_clamped = 16'd65530;
    end
  end

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state     <= IDLE;
      pkt_cnt   <= '0;
      pkt_sent  <= '0;
      beat      <= '0;
      lat_len   <= '0;
      lat_sid   <= '0;
      lat_tsi   <= '0;
      lat_tsf   <= '0;
      pro_data  <= '0;
      pro_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && S_AXIS.TVALID) begin
            lat_len   <= len_clamped;
            lat_sid   <= stream_id;
            lat_tsi   <= tsi;
            lat_tsf   <= tsf;
            pro_data  <= {4'b0001, 2'b00, 2'b00, 2'b01, 2'b10, pkt_cnt,
                          len_clamped + 16'd5};
            pro_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= HDR;
          end
        end
        // Each prologue word is loaded one state ahead so TDATA is a register.
        HDR: if (M_AXIS.TREADY) begin
          pro_data <= lat_sid;
          state    <= SID;
        end
        SID: if (M_AXIS.TREADY) begin
          pro_data <= lat_tsi;
          state    <= TSI;
        end
        TSI: if (M_AXIS.TREADY) begin
          pro_data <= lat_tsf[63:32];
          state    <= TSF_HI;
        end
        TSF_HI: if (M_AXIS.TREADY) begin
          pro_data <= lat_tsf[31:0];
          state    <= TSF_LO;
        end
        TSF_LO: if (M_AXIS.TREADY) begin
          pro_data  <= '0;
          pro_valid <= 1'b0;
          beat      <= '0;
          state     <= PAYLOAD;
        end
        PAYLOAD: begin
          if (S_AXIS.TVALID && M_AXIS.TREADY) begin
            if (beat == last_beat) begin
              beat     <= '0;
              pkt_cnt  <= pkt_cnt + 4'd1;
              pkt_sent <= pkt_sent + 32'd1;
              busy     <= 1'b0;
              state    <= IDLE;
            end else begin
              beat <= beat + 16'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    M_AXIS.TVALID = pro_valid;
    M_AXIS.TDATA  = pro_data;
    M_AXIS.TSTRB  = pro_valid ? '1 : '0;
    M_AXIS.TLAST  = 1'b0;
    S_AXIS.TREADY = 1'b0;
    if (state == PAYLOAD) begin
      M_AXIS.TVALID = S_AXIS.TVALID;
      M_AXIS.TDATA  = S_AXIS.TDATA;
      M_AXIS.TSTRB  = S_AXIS.TSTRB;
      M_AXIS.TLAST  = (beat == last_beat);
      S_AXIS.TREADY = M_AXIS.TREADY;
    end
  end

endmodule
